dht11_sensor_emu: RTL and testbench

Single-wire DHT11 sensor emulator: the responder end of the DHT11 protocol. It watches the open-drain data line for a host start pulse, then drives the standard response and a 40-bit frame built from its input values. It is used as an on-board stand-in for the physical sensor, so the DHT11 reader and 7-segment display path can be exercised board-to-board or in simulation. It drives low only and never drives high; an external pull-up supplies the high level.

---
 rtl/dht11_sensor_emu.sv | 234 +++++++++++++++++++++++
 tb/tb_dht11_sensor_emu.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_sensor_emu.sv
// dht11_sensor_emu
// ----------------
// Responder end of the single-wire DHT11 protocol, used as a stand-in for the
// physical sensor. It watches the open-drain data line for a host start pulse,
// then sends the response preamble and a 40-bit frame
// {humidity, humi_dec, temperature, tmpr_dec, checksum}, MSB first.
// The line is only ever pulled low; the high level comes from the pull-up.
//
// Ports:
//   clk          system clock
//   reset_p      synchronous active-high reset (aborts any frame in flight)
//   dht11_data   open-drain bus, driven 0 or Z only
//   humidity     integer humidity byte to report
//   humi_dec     humidity decimal byte
//   temperature  integer temperature byte to report
//   tmpr_dec     temperature decimal byte
//   busy         high from start acceptance until the line is released after the frame
//   frame_done   one-cycle pulse when a frame completes
//   frame_cnt    number of completed frames, wraps 255 -> 0

module dht11_sensor_emu #(
    parameter int CLKS_PER_US  = 100,
    parameter int START_MIN_US = 18000,
    parameter int TURN_US      = 30,
    parameter int RESP_LOW_US  = 80,
    parameter int RESP_HIGH_US = 80,
    parameter int BIT_LOW_US   = 50,
    parameter int BIT0_HIGH_US = 26,
    parameter int BIT1_HIGH_US = 70
) (
    input  logic       clk,
    input  logic       reset_p,
    inout  wire        dht11_data,
    input  logic [7:0] humidity,
    input  logic [7:0] humi_dec,
    input  logic [7:0] temperature,
    input  logic [7:0] tmpr_dec,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    localparam int START_CYC     = START_MIN_US * CLKS_PER_US;
    localparam int TURN_CYC      = TURN_US      * CLKS_PER_US;
    localparam int RESP_LOW_CYC  = RESP_LOW_US  * CLKS_PER_US;
    localparam int RESP_HIGH_CYC = RESP_HIGH_US * CLKS_PER_US;
    localparam int BIT_LOW_CYC   = BIT_LOW_US   * CLKS_PER_US;
    localparam int BIT0_CYC      = BIT0_HIGH_US * CLKS_PER_US;
    localparam int BIT1_CYC      = BIT1_HIGH_US * CLKS_PER_US;

    // The single timer must hold the longest interval of any phase.
    localparam int MAX_A   = (START_CYC > TURN_CYC) ? START_CYC : TURN_CYC;
    localparam int MAX_B   = (RESP_LOW_CYC > RESP_HIGH_CYC) ? RESP_LOW_CYC : RESP_HIGH_CYC;
    localparam int MAX_C   = (BIT_LOW_CYC > BIT1_CYC) ? BIT_LOW_CYC : BIT1_CYC;
    localparam int MAX_D   = (BIT0_CYC > MAX_C) ? BIT0_CYC : MAX_C;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_AB > MAX_D) ? MAX_AB : MAX_D;
    localparam int TW      = $clog2(MAX_CYC + 1);

    // Terminal counts: a phase of N cycles ends when the timer reads N-1, so
    // the registered drive level holds for exactly N cycles.
    localparam logic [TW-1:0] START_END     = TW'(START_CYC - 1);
    localparam logic [TW-1:0] TURN_END      = TW'(TURN_CYC - 1);
    localparam logic [TW-1:0] RESP_LOW_END  = TW'(RESP_LOW_CYC - 1);
    localparam logic [TW-1:0] RESP_HIGH_END = TW'(RESP_HIGH_CYC - 1);
    localparam logic [TW-1:0] BIT_LOW_END   = TW'(BIT_LOW_CYC - 1);
    localparam logic [TW-1:0] BIT0_END      = TW'(BIT0_CYC - 1);
    localparam logic [TW-1:0] BIT1_END      = TW'(BIT1_CYC - 1);
    localparam logic [TW-1:0] TIMER_ONE     = TW'(1);

    typedef enum logic [3:0] {
        IDLE,
        ARMED,
        TURN,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW,
        RELEASE
    } state_t;

    state_t          state_reg;
    logic [TW-1:0]   timer_reg;
    logic [5:0]      bit_idx_reg;
    logic [39:0]     shift_reg;
    logic            drive_low_reg;
    logic            busy_reg;
    logic            frame_done_reg;
    logic [7:0]      frame_cnt_reg;
    logic            sync_meta_reg;
    logic            sync_line_reg;
    logic [7:0]      checksum;
    logic [TW-1:0]   bit_high_end;

    assign dht11_data = drive_low_reg ? 1'b0 : 1'bz;

    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign frame_cnt  = frame_cnt_reg;

    // 8-bit sum wraps naturally, giving the mod-256 checksum.
    assign checksum = humidity + humi_dec + temperature + tmpr_dec;

    // High time of the bit currently at the top of the shift word.
    assign bit_high_end = shift_reg[39] ? BIT1_END : BIT0_END;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            drive_low_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_cnt_reg  <= '0;
            // Idle bus level is high, so the synchronizer starts there.
            sync_meta_reg  <= 1'b1;
            sync_line_reg  <= 1'b1;
        end else begin
            sync_meta_reg  <= dht11_data;
            sync_line_reg  <= sync_meta_reg;
            frame_done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (sync_line_reg) begin
                        timer_reg <= '0;            // short pulse ignored
                    end else if (timer_reg == START_END) begin
                        timer_reg <= '0;
                        state_reg <= ARMED;
                    end else begin
                        timer_reg <= timer_reg + TIMER_ONE;
                    end
                end

                ARMED: begin
                    if (sync_line_reg) begin
                        shift_reg <= {humidity, humi_dec, temperature, tmpr_dec, checksum};
                        busy_reg  <= 1'b1;
                        timer_reg <= '0;
                        state_reg <= TURN;
                    end
                end

                TURN: begin
                    if (timer_reg == TURN_END) begin
                        timer_reg     <= '0;
                        drive_low_reg <= 1'b1;
                        state_reg     <= RESP_LOW;
                    end else begin
                        timer_reg <= timer_reg + TIMER_ONE;
                    end
                end

                RESP_LOW: begin
                    if (timer_reg == RESP_LOW_END) begin
                        timer_reg     <= '0;
                        drive_low_reg <= 1'b0;
                        state_reg     <= RESP_HIGH;
                    end else begin
                        timer_reg <= timer_reg + TIMER_ONE;
                    end
                end

                RESP_HIGH: begin
                    if (timer_reg == RESP_HIGH_END) begin
                        timer_reg     <= '0;
                        bit_idx_reg   <= '0;
                        drive_low_reg <= 1'b1;
                        state_reg     <= BIT_LOW;
                    end else begin
                        timer_reg <= timer_reg + TIMER_ONE;
                    end
                end

                BIT_LOW: begin
                    if (timer_reg == BIT_LOW_END) begin
                        timer_reg     <= '0;
                        drive_low_reg <= 1'b0;
                        state_reg     <= BIT_HIGH;
                    end else begin
                        timer_reg <= timer_reg + TIMER_ONE;
                    end
                end

                BIT_HIGH: begin
                    if (timer_reg == bit_high_end) begin
                        timer_reg     <= '0;
                        drive_low_reg <= 1'b1;
                        if (bit_idx_reg == 6'd39) begin
                            state_reg <= END_LOW;
                        end else begin
                            shift_reg   <= {shift_reg[38:0], 1'b0};
                            bit_idx_reg <= bit_idx_reg + 6'd1;
                            state_reg   <= BIT_LOW;
                        end
                    end else begin
                        timer_reg <= timer_reg + TIMER_ONE;
                    end
                end

                END_LOW: begin
                    if (timer_reg == BIT_LOW_END) begin
                        timer_reg     <= '0;
                        drive_low_reg <= 1'b0;
                        state_reg     <= RELEASE;
                    end else begin
                        timer_reg <= timer_reg + TIMER_ONE;
                    end
                end

                RELEASE: begin
                    // Synchronized value lags our own release by two cycles.
                    if (sync_line_reg) begin
                        busy_reg       <= 1'b0;
                        frame_done_reg <= 1'b1;
                        frame_cnt_reg  <= frame_cnt_reg + 8'd1;
                        timer_reg      <= '0;
                        state_reg      <= IDLE;
                    end
                end

                default: begin
                    drive_low_reg <= 1'b0;
                    timer_reg     <= '0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Testbench for dht11_sensor_emu. A host process issues start pulses and pushes
// the frame a DHT11 responder must send into a queue; a line decoder sampling on
// the falling clock edge measures every phase of the waveform, rebuilds the
// 40-bit word from the measured high times and compares against the queue.
// Timing parameters are scaled down so that 256 frames fit a short run.

`timescale 1ns/1ps

module tb_dht11_sensor_emu;

    localparam int CPU       = 1;
    localparam int START_US  = 10;
    localparam int TURN_US   = 3;
    localparam int RL_US     = 4;
    localparam int RH_US     = 4;
    localparam int BL_US     = 1;
    localparam int B0_US     = 1;
    localparam int B1_US     = 2;

    localparam int START_CYC = START_US * CPU;
    localparam int TURN_CYC  = TURN_US * CPU;
    localparam int RL_CYC    = RL_US * CPU;
    localparam int RH_CYC    = RH_US * CPU;
    localparam int BL_CYC    = BL_US * CPU;
    localparam int B0_CYC    = B0_US * CPU;
    localparam int B1_CYC    = B1_US * CPU;

    localparam int D_IDLE  = 0;
    localparam int D_RLOW  = 1;
    localparam int D_RHIGH = 2;
    localparam int D_BLOW  = 3;
    localparam int D_BHIGH = 4;
    localparam int D_END   = 5;
    localparam int D_DONE  = 6;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       host_low;
    logic [7:0] humidity, humi_dec, temperature, tmpr_dec;
    logic       busy, frame_done;
    logic [7:0] frame_cnt;
    wire        dht11_data;

    assign dht11_data = host_low ? 1'b0 : 1'bz;
    pullup (dht11_data);

    dht11_sensor_emu #(
        .CLKS_PER_US (CPU),
        .START_MIN_US(START_US),
        .TURN_US     (TURN_US),
        .RESP_LOW_US (RL_US),
        .RESP_HIGH_US(RH_US),
        .BIT_LOW_US  (BL_US),
        .BIT0_HIGH_US(B0_US),
        .BIT1_HIGH_US(B1_US)
    ) dut (
        .clk        (clk),
        .reset_p    (reset_p),
        .dht11_data (dht11_data),
        .humidity   (humidity),
        .humi_dec   (humi_dec),
        .temperature(temperature),
        .tmpr_dec   (tmpr_dec),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [39:0] exp_q[$];

    // decoder state
    int          cyc       = 0;
    int          rel_cyc   = 0;
    int          dstate    = D_IDLE;
    int          run_len   = 0;
    int          nbits     = 0;
    int          wait_cnt  = 0;
    int          model_cnt = 0;
    int          fd_count  = 0;
    bit          prev_line = 1'b1;
    bit          ln;
    bit          bitv;
    logic [39:0] word;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference frame: the four bytes followed by their mod-256 sum.
    function automatic logic [39:0] model_frame(input int h, input int hd, input int t, input int td);
        int s;
        s = (h + hd + t + td) % 256;
        return {h[7:0], hd[7:0], t[7:0], td[7:0], s[7:0]};
    endfunction

    // Waveform decoder / scoreboard checker.
    always @(negedge clk) begin
        ln = (dht11_data !== 1'b0);
        cyc++;
        if (reset_p) begin
            dstate    = D_IDLE;
            model_cnt = 0;
            prev_line = ln;
            run_len   = 1;
        end else begin
            if (frame_done) begin
                fd_count++;
                if (dstate == D_DONE) begin
                    model_cnt = (model_cnt + 1) % 256;
                    chk("frame_cnt", frame_cnt, model_cnt);
                    dstate = D_IDLE;
                end else begin
                    chk("frame_done_unexpected", 1, 0);
                end
            end

            if (ln != prev_line) begin
                if (!ln) begin
                    case (dstate)
                        D_IDLE: begin
                            if (!host_low) begin
                                if (exp_q.size() == 0) begin
                                    chk("spurious_response", 1, 0);
                                end else begin
                                    chk_rng("turn_delay", cyc - rel_cyc, TURN_CYC, TURN_CYC + 4);
                                    dstate = D_RLOW;
                                end
                            end
                        end
                        D_RHIGH: begin
                            chk("resp_high", run_len, RH_CYC);
                            nbits  = 0;
                            word   = '0;
                            dstate = D_BLOW;
                        end
                        D_BHIGH: begin
                            if (exp_q.size() == 0) begin
                                chk("bit_without_frame", 1, 0);
                                dstate = D_IDLE;
                            end else begin
                                bitv = exp_q[0][39 - nbits];
                                chk("bit_high", run_len, bitv ? B1_CYC : B0_CYC);
                                word = {word[38:0], (run_len == B1_CYC)};
                                nbits++;
                                dstate = (nbits == 40) ? D_END : D_BLOW;
                            end
                        end
                        default: begin
                            chk("falling_edge_phase", dstate, -1);
                            dstate = D_IDLE;
                        end
                    endcase
                end else begin
                    case (dstate)
                        D_IDLE: ;
                        D_RLOW: begin
                            chk("resp_low", run_len, RL_CYC);
                            dstate = D_RHIGH;
                        end
                        D_BLOW: begin
                            chk("bit_low", run_len, BL_CYC);
                            dstate = D_BHIGH;
                        end
                        D_END: begin
                            chk("end_low", run_len, BL_CYC);
                            if (exp_q.size() == 0) begin
                                chk("word_without_frame", 1, 0);
                                dstate = D_IDLE;
                            end else begin
                                chk("frame_word", word, exp_q[0]);
                                $display("frame %0d word=%010h expected=%010h", fd_count + 1, word, exp_q[0]);
                                void'(exp_q.pop_front());
                                wait_cnt = 0;
                                dstate   = D_DONE;
                            end
                        end
                        default: begin
                            chk("rising_edge_phase", dstate, -1);
                            dstate = D_IDLE;
                        end
                    endcase
                end
                prev_line = ln;
                run_len   = 1;
            end else begin
                run_len++;
            end

            if (dstate == D_DONE) begin
                wait_cnt++;
                if (wait_cnt > 10) begin
                    chk("frame_done_timeout", 0, 1);
                    dstate = D_IDLE;
                end
            end else if (dstate != D_IDLE && run_len > 100) begin
                chk("line_stuck", run_len, 0);
                dstate = D_IDLE;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_bits(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ((dstate == D_BLOW || dstate == D_BHIGH) && nbits >= n) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        chk("reach_bit", ok, 1);
    endtask

    // One host transaction: low for low_cyc cycles, then release. change_at >= 0
    // zeroes the inputs once that many bits have gone out.
    task automatic run_frame(input int h, input int hd, input int t, input int td,
                             input int low_cyc, input int change_at);
        bit accepted;
        bit ok = 1'b0;
        humidity    = h[7:0];
        humi_dec    = hd[7:0];
        temperature = t[7:0];
        tmpr_dec    = td[7:0];
        host_low = 1'b1;
        step(low_cyc);
        accepted = (low_cyc >= START_CYC);
        if (accepted) exp_q.push_back(model_frame(h, hd, t, td));
        rel_cyc  = cyc;
        host_low = 1'b0;
        if (accepted) begin
            if (change_at >= 0) begin
                wait_bits(change_at);
                humidity = 8'h00; humi_dec = 8'h00; temperature = 8'h00; tmpr_dec = 8'h00;
            end
            for (int i = 0; i < 3000; i++) begin
                if (dstate == D_IDLE && exp_q.size() == 0 && !busy) begin
                    ok = 1'b1;
                    break;
                end
                step(1);
            end
            chk("frame_complete", ok, 1);
            if (!ok) exp_q.delete();
        end else begin
            step(TURN_CYC + 20);
            chk("short_pulse_busy", busy, 0);
        end
        step(2);
    endtask

    initial begin
        int fd_base;
        reset_p  = 1'b1;
        host_low = 1'b0;
        humidity = '0; humi_dec = '0; temperature = '0; tmpr_dec = '0;
        step(5);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_line", dht11_data !== 1'b0, 1);
        step(1);
        reset_p = 1'b0;
        step(3);

        // Abort mid-frame during bit 20, then check the line is released.
        humidity = 8'h5A; humi_dec = 8'h01; temperature = 8'h22; tmpr_dec = 8'h07;
        host_low = 1'b1;
        step(START_CYC + 2);
        exp_q.push_back(model_frame(8'h5A, 8'h01, 8'h22, 8'h07));
        rel_cyc  = cyc;
        host_low = 1'b0;
        wait_bits(20);
        reset_p = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("abort_line", dht11_data !== 1'b0, 1);
        chk("abort_busy", busy, 0);
        chk("abort_frame_cnt", frame_cnt, 0);
        step(1);
        reset_p = 1'b0;
        step(5);

        // Directed frame: bytes 0x37,0x00,0x18,0x00,0x4F.
        run_frame(55, 0, 24, 0, START_CYC + 5, -1);
        chk("first_frame_cnt", frame_cnt, 1);

        // Short pulse ignored, following pulse accepted; threshold boundary.
        run_frame(1, 2, 3, 4, START_CYC - 1, -1);
        run_frame(1, 2, 3, 4, START_CYC + 2, -1);
        run_frame(9, 8, 7, 6, START_CYC, -1);

        // All 0xFF with inputs cleared during bit 5.
        run_frame(255, 255, 255, 255, START_CYC + 1, 5);

        // Random data and random host low times.
        for (int i = 0; i < 10; i++) begin
            run_frame($urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(1, 2 * START_CYC), -1);
        end

        // 256 back-to-back frames from reset: counter must wrap back to 0.
        reset_p = 1'b1;
        step(3);
        reset_p = 1'b0;
        step(2);
        fd_base = fd_count;
        for (int i = 0; i < 256; i++) begin
            run_frame($urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 255), $urandom_range(0, 255),
                      START_CYC, -1);
        end
        chk("wrap_frame_cnt", frame_cnt, 0);
        chk("wrap_done_pulses", fd_count - fd_base, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
